// File: rtl/i2s_tdm_tx.sv
`default_nettype none
// i2s_tdm_tx: N-channel I2S / left-justified TDM transmitter with a frame FIFO and underrun pulse.
// Define I2S_TDM_TX_MUTE_ON_UNDERRUN_EN to send silence on underrun instead of repeating the last frame.
module i2s_tdm_tx #(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 16,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESC_W    = 8,
  parameter int LEFT_JUST  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PRESC_W-1:0]           prescaler,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*SAMPLE_W-1:0] in_data,
  output logic                         sclk,
  output logic                         lrclk,
  output logic                         sdata,
  output logic                         underrun,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
  localparam int DW = CHANNELS * SAMPLE_W;
  localparam int FW = CHANNELS * SLOT_W;
  localparam int BW = $clog2(FW);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [BW-1:0] LAST_B = BW'(FW - 1);
  localparam logic [BW-1:0] HALF_B = BW'(FW / 2);
  localparam logic [LW-1:0] FULL   = LW'(FIFO_DEPTH);

  logic [PRESC_W-1:0] cnt_q, cnt_d, per_q, per_d, w_per;
  logic               sclk_q, sclk_d, fall_q, fall_d, lrclk_q, lrclk_d;
  logic               und_q, und_d, rdy_q, rdy_d;
  logic [BW-1:0]      b_q, b_d, w_nb;
  logic [FW-1:0]      shift_q, shift_d, w_head, w_fill;
  logic [AW-1:0]      wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0]      lvl_q, lvl_d;
  logic [DW-1:0]      mem_q [FIFO_DEPTH];
  logic               w_tog, w_wrap, w_push, w_pop;

  // Expand the FIFO head into slots: ch0 leads, each sample MSB-aligned with zero padding.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
    assign w_head[FW-1-k*SLOT_W -: SLOT_W] =
      SLOT_W'(mem_q[rp_q][k*SAMPLE_W +: SAMPLE_W]) << (SLOT_W - SAMPLE_W);
  end

`ifdef I2S_TDM_TX_MUTE_ON_UNDERRUN_EN
  assign w_fill = '0;
`else
  logic [FW-1:0] last_q;
  always_ff @(posedge clk) begin
    if (rst)        last_q <= '0;
    else if (w_pop) last_q <= w_head;
  end
  assign w_fill = last_q;
`endif

  always_comb begin
    w_per   = (prescaler == '0) ? PRESC_W'(1) : prescaler;
    w_tog   = (cnt_q == per_q - PRESC_W'(1));
    cnt_d   = w_tog ? '0 : cnt_q + PRESC_W'(1);
    per_d   = w_tog ? w_per : per_q;
    sclk_d  = w_tog ? ~sclk_q : sclk_q;
    fall_d  = w_tog & sclk_q;
    w_wrap  = fall_q && (b_q == LAST_B);
    w_pop   = w_wrap && (lvl_q != '0);
    w_push  = in_valid && rdy_q;
    b_d     = b_q;
    shift_d = shift_q;
    und_d   = 1'b0;
    if (w_wrap) begin
      b_d     = '0;
      shift_d = w_pop ? w_head : w_fill;
      und_d   = ~w_pop;
    end else if (fall_q) begin
      b_d     = b_q + BW'(1);
      shift_d = shift_q << 1;
    end
    // In I2S mode lrclk reflects the slot of the following bit.
    w_nb    = (b_d == LAST_B) ? '0 : b_d + BW'(1);
    lrclk_d = (LEFT_JUST != 0) ? (b_d >= HALF_B) : (w_nb >= HALF_B);
    wp_d    = wp_q + AW'(w_push);
    rp_d    = rp_q + AW'(w_pop);
    lvl_d   = lvl_q + LW'(w_push) - LW'(w_pop);
    rdy_d   = (lvl_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      per_q   <= w_per;
      sclk_q  <= 1'b0;
      fall_q  <= 1'b0;
      b_q     <= '0;
      lrclk_q <= 1'b0;
      shift_q <= '0;
      und_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      lvl_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      sclk_q  <= sclk_d;
      fall_q  <= fall_d;
      b_q     <= b_d;
      lrclk_q <= lrclk_d;
      shift_q <= shift_d;
      und_q   <= und_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      lvl_q   <= lvl_d;
      rdy_q   <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wp_q] <= in_data;
  end

  assign sclk       = sclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = shift_q[FW-1];
  assign underrun   = und_q;
  assign fifo_level = lvl_q;
  assign in_ready   = rdy_q;
endmodule
`default_nettype wire

// File: tb/tb_i2s_tdm_tx.sv
`timescale 1ns/1ps
`default_nettype none
module tb_i2s_tdm_tx;
  typedef logic [3:0][31:0] frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [7:0]  presc0 = 8'd2, presc1 = 8'd0;
  logic        v0 = 1'b0, v1 = 1'b0;
  frame_t      f0 = '0, f1 = '0;
  logic [31:0] d0;
  logic [95:0] d1;
  logic        rdy0, rdy1, sclk0, sclk1, lr0, lr1, sd0, sd1, ur0, ur1;
  logic [2:0]  lvl0;
  logic [1:0]  lvl1;

  assign d0 = {f0[1][15:0], f0[0][15:0]};
  assign d1 = {f1[3][23:0], f1[2][23:0], f1[1][23:0], f1[0][23:0]};

  i2s_tdm_tx #(.SAMPLE_W(16), .SLOT_W(16), .CHANNELS(2), .FIFO_DEPTH(4), .PRESC_W(8), .LEFT_JUST(0)) u0 (
    .clk(clk), .rst(rst), .prescaler(presc0), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
    .sclk(sclk0), .lrclk(lr0), .sdata(sd0), .underrun(ur0), .fifo_level(lvl0));

  i2s_tdm_tx #(.SAMPLE_W(24), .SLOT_W(32), .CHANNELS(4), .FIFO_DEPTH(2), .PRESC_W(8), .LEFT_JUST(1)) u1 (
    .clk(clk), .rst(rst), .prescaler(presc1), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .sclk(sclk1), .lrclk(lr1), .sdata(sd1), .underrun(ur1), .fifo_level(lvl1));

  // Reference model: time since reset drives an arithmetic bit schedule; frames live in queues.
  int     checks = 0, errors = 0;
  int     t [2], per [2];
  logic   und [2], rdy [2], acc [2];
  frame_t cur [2], last [2];
  frame_t fq0 [$], fq1 [$];
  logic   rnd0 = 1'b0, rnd1 = 1'b0;

  function automatic int fw(int i);    return (i == 0) ? 32 : 128; endfunction
  function automatic int slotw(int i); return (i == 0) ? 16 : 32;  endfunction
  function automatic int sampw(int i); return (i == 0) ? 16 : 24;  endfunction
  function automatic int lj(int i);    return (i == 0) ? 0 : 1;    endfunction
  function automatic int depth(int i); return (i == 0) ? 4 : 2;    endfunction
  function automatic int qsz(int i);   return (i == 0) ? fq0.size() : fq1.size(); endfunction

  function automatic int bidx(int i);
    int adv;
    adv = (t[i] == 0) ? 0 : (t[i] - 1) / (2 * per[i]);
    return adv % fw(i);
  endfunction

  function automatic logic exp_bit(int i, int b);
    int s, o;
    s = b / slotw(i);
    o = b % slotw(i);
    if (o < sampw(i)) return cur[i][s][sampw(i) - 1 - o];
    return 1'b0;
  endfunction

  function automatic frame_t rand_frame();
    frame_t fr;
    for (int s = 0; s < 4; s++) fr[s] = $urandom();
    return fr;
  endfunction

  task automatic model_edge(input int i, input logic valid, input frame_t fr, input int presc);
    if (rst) begin
      t[i] = 0; per[i] = (presc == 0) ? 1 : presc;
      cur[i] = '0; last[i] = '0; rdy[i] = 1'b0; und[i] = 1'b0; acc[i] = 1'b0;
      if (i == 0) fq0.delete(); else fq1.delete();
    end else begin
      t[i]++;
      und[i] = 1'b0;
      acc[i] = 1'b0;
      if (t[i] > 1 && (t[i] - 1) % (2 * fw(i) * per[i]) == 0) begin
        if (qsz(i) > 0) begin
          if (i == 0) cur[i] = fq0.pop_front(); else cur[i] = fq1.pop_front();
          last[i] = cur[i];
        end else begin
          und[i] = 1'b1;
`ifdef I2S_TDM_TX_MUTE_ON_UNDERRUN_EN
          cur[i] = '0;
`else
          cur[i] = last[i];
`endif
        end
      end
      if (valid && rdy[i]) begin
        if (i == 0) fq0.push_back(fr); else fq1.push_back(fr);
        acc[i] = 1'b1;
      end
      rdy[i] = (qsz(i) != depth(i));
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic s, input logic l, input logic d,
                            input logic u, input logic [31:0] lv, input logic r);
    int b;
    logic el;
    b  = bidx(i);
    el = (lj(i) != 0) ? (b >= fw(i) / 2) : (((b + 1) % fw(i)) >= fw(i) / 2);
    check($sformatf("u%0d sclk t=%0d", i, t[i]), 32'(s), 32'((t[i] / per[i]) % 2));
    check($sformatf("u%0d lrclk t=%0d b=%0d", i, t[i], b), 32'(l), 32'(el));
    check($sformatf("u%0d sdata t=%0d b=%0d", i, t[i], b), 32'(d), 32'(exp_bit(i, b)));
    check($sformatf("u%0d underrun t=%0d", i, t[i]), 32'(u), 32'(und[i]));
    check($sformatf("u%0d fifo_level t=%0d", i, t[i]), lv, 32'(qsz(i)));
    check($sformatf("u%0d in_ready t=%0d", i, t[i]), 32'(r), 32'(rdy[i]));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      if (rnd0) begin v0 = ($urandom_range(0, 63) == 0); f0 = rand_frame(); end
      if (rnd1) begin v1 = ($urandom_range(0, 31) == 0); f1 = rand_frame(); end
      model_edge(0, v0, f0, int'(presc0));
      model_edge(1, v1, f1, int'(presc1));
      @(posedge clk);
      @(negedge clk);
      check_inst(0, sclk0, lr0, sd0, ur0, 32'(lvl0), rdy0);
      check_inst(1, sclk1, lr1, sd1, ur1, 32'(lvl1), rdy1);
    end
  endtask

  task automatic push0(input frame_t fr);
    int n;
    f0 = fr;
    v0 = 1'b1;
    n  = 0;
    do begin
      run(1);
      n++;
    end while (!acc[0] && n < 1000);
    check("u0 push accepted", 32'(acc[0]), 32'd1);
    v0 = 1'b0;
  endtask

  initial begin
    frame_t fr;
    int n;
    @(negedge clk);
    // Reset held 5 clk, then release and let the zero frame play out.
    rst = 1'b1;
    run(5);
    rst = 1'b0;
    rnd1 = 1'b1;
    run(3);
    // Directed stereo frame: ch0=A5F0, ch1=1234.
    fr = '0; fr[0] = 32'hA5F0; fr[1] = 32'h1234;
    push0(fr);
    run(400);
    // Fill the FIFO: four fast pushes, the fifth waits for a frame-boundary pop.
    for (int k = 0; k < 5; k++) begin
      fr = rand_frame();
      if (k == 4) begin fr[0] = 32'h7FFF; fr[1] = 32'h8000; end
      f0 = fr;
      v0 = 1'b1;
      n  = 0;
      do begin
        run(1);
        n++;
      end while (!acc[0] && n < 1000);
      check($sformatf("u0 fill push %0d accepted", k), 32'(acc[0]), 32'd1);
    end
    v0 = 1'b0;
    // Drain to underrun; the 7FFF/8000 frame should repeat or mute afterwards.
    run(1200);
    // Reset mid-frame at b=10 and restart with a different prescaler.
    n = 0;
    while (bidx(0) != 10 && n < 500) begin run(1); n++; end
    check("u0 reached b=10", 32'(bidx(0)), 32'd10);
    rst = 1'b1;
    presc0 = 8'd3;
    run(1);
    rst = 1'b0;
    run(300);
    fr = '0; fr[0] = 32'h8001; fr[1] = 32'h00FF;
    push0(fr);
    rnd0 = 1'b1;
    run(2500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
